// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the VGA timing generator to the renderer and pins.
interface vga_timing_gen_if;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       video_on;
   logic       hsync;
   logic       vsync;
   logic       frame_start;
   logic       vblank_start;
   logic [7:0] frame_count;

   modport master (
      output pixel_x, pixel_y, video_on, hsync, vsync,
             frame_start, vblank_start, frame_count
   );

   modport slave (
      input  pixel_x, pixel_y, video_on, hsync, vsync,
             frame_start, vblank_start, frame_count
   );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel/line counters, registered video flags,
// delayed active-low syncs and a frame counter.
module vga_timing_gen #(
   parameter int H_VIDEO    = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_VIDEO    = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int SYNC_DELAY = 2
) (
   input  logic              clk_0,
   input  logic              rst,
   vga_timing_gen_if.master  vga
);

   localparam logic [9:0] H_ACT  = 10'(H_VIDEO);
   localparam logic [9:0] H_MAX  = 10'(H_VIDEO + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] H_SS   = 10'(H_VIDEO + H_FRONT);
   localparam logic [9:0] H_SE   = 10'(H_VIDEO + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] V_ACT  = 10'(V_VIDEO);
   localparam logic [9:0] V_MAX  = 10'(V_VIDEO + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0] V_SS   = 10'(V_VIDEO + V_FRONT);
   localparam logic [9:0] V_SE   = 10'(V_VIDEO + V_FRONT + V_SYNC - 1);

   logic [9:0]            x_q, y_q;
   logic [9:0]            x_next, y_next;
   logic                  video_on_q, frame_start_q, vblank_start_q;
   logic [7:0]            frame_count_q;
   logic                  hsync_raw, vsync_raw;
   logic                  vblank_next;
   logic [SYNC_DELAY-1:0] hs_pipe, vs_pipe;

   always_comb begin
      x_next = x_q + 10'd1;
      y_next = y_q;
      if (x_q == H_MAX) begin
         x_next = 10'd0;
         y_next = (y_q == V_MAX) ? 10'd0 : y_q + 10'd1;
      end
   end

   assign vblank_next = (x_next == 10'd0) && (y_next == V_ACT);

   // Flags look at the next count so they line up with the counter registers.
   always_ff @(posedge clk_0) begin
      if (!rst) begin
         x_q            <= H_MAX;
         y_q            <= V_MAX;
         video_on_q     <= 1'b0;
         frame_start_q  <= 1'b0;
         vblank_start_q <= 1'b0;
         frame_count_q  <= 8'd0;
      end else begin
         x_q            <= x_next;
         y_q            <= y_next;
         video_on_q     <= (x_next < H_ACT) && (y_next < V_ACT);
         frame_start_q  <= (x_next == 10'd0) && (y_next == 10'd0);
         vblank_start_q <= vblank_next;
         if (vblank_next) begin
            frame_count_q <= frame_count_q + 8'd1;
         end
      end
   end

   assign hsync_raw = !((x_q >= H_SS) && (x_q <= H_SE));
   assign vsync_raw = !((y_q >= V_SS) && (y_q <= V_SE));

   // Sync delay matches the renderer's colour pipeline; reset forces idle-high.
   if (SYNC_DELAY == 1) begin : g_delay_one
      always_ff @(posedge clk_0) begin
         if (!rst) begin
            hs_pipe <= '1;
            vs_pipe <= '1;
         end else begin
            hs_pipe <= hsync_raw;
            vs_pipe <= vsync_raw;
         end
      end
   end else begin : g_delay_multi
      always_ff @(posedge clk_0) begin
         if (!rst) begin
            hs_pipe <= '1;
            vs_pipe <= '1;
         end else begin
            hs_pipe <= {hs_pipe[SYNC_DELAY-2:0], hsync_raw};
            vs_pipe <= {vs_pipe[SYNC_DELAY-2:0], vsync_raw};
         end
      end
   end

   assign vga.pixel_x      = x_q;
   assign vga.pixel_y      = y_q;
   assign vga.video_on     = video_on_q;
   assign vga.frame_start  = frame_start_q;
   assign vga.vblank_start = vblank_start_q;
   assign vga.frame_count  = frame_count_q;
   assign vga.hsync        = hs_pipe[SYNC_DELAY-1];
   assign vga.vsync        = vs_pipe[SYNC_DELAY-1];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing plus reduced-height and
// tiny rasters so frame-level behaviour fits a short run.
module tb_vga_timing_gen;

   logic clk;
   logic rst_full, rst_d1, rst_d4, rst_v, rst_t;
   int   passed = 0;
   int   total  = 0;

   vga_timing_gen_if if_full ();
   vga_timing_gen_if if_d1 ();
   vga_timing_gen_if if_d4 ();
   vga_timing_gen_if if_v ();
   vga_timing_gen_if if_t ();

   vga_timing_gen u_full (.clk_0(clk), .rst(rst_full), .vga(if_full));
   vga_timing_gen #(.SYNC_DELAY(1)) u_d1 (.clk_0(clk), .rst(rst_d1), .vga(if_d1));
   vga_timing_gen #(.SYNC_DELAY(4)) u_d4 (.clk_0(clk), .rst(rst_d4), .vga(if_d4));
   // 10 lines per frame; V_SYNC stays 2 so vsync is still 1600 cycles low
   vga_timing_gen #(.V_VIDEO(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2))
      u_v (.clk_0(clk), .rst(rst_v), .vga(if_v));
   // 8 x 5 raster = 40 cycles per frame
   vga_timing_gen #(.H_VIDEO(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                    .V_VIDEO(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1))
      u_t (.clk_0(clk), .rst(rst_t), .vga(if_t));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [9:0] px(input int s);
      case (s)
         0: return if_full.pixel_x;
         1: return if_d1.pixel_x;
         2: return if_d4.pixel_x;
         3: return if_v.pixel_x;
         default: return if_t.pixel_x;
      endcase
   endfunction

   function automatic logic [9:0] py(input int s);
      case (s)
         0: return if_full.pixel_y;
         1: return if_d1.pixel_y;
         2: return if_d4.pixel_y;
         3: return if_v.pixel_y;
         default: return if_t.pixel_y;
      endcase
   endfunction

   function automatic logic hs(input int s);
      case (s)
         0: return if_full.hsync;
         1: return if_d1.hsync;
         2: return if_d4.hsync;
         3: return if_v.hsync;
         default: return if_t.hsync;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_xy(input int s, input logic [9:0] x, input logic [9:0] y,
                          input int budget, output bit ok);
      int n;
      n = 0;
      while (!(px(s) == x && py(s) == y) && n < budget) begin
         tick();
         n++;
      end
      ok = (px(s) == x && py(s) == y);
   endtask

   task automatic wait_x(input int s, input logic [9:0] x, input int budget, output bit ok);
      int n;
      n = 0;
      while (px(s) != x && n < budget) begin
         tick();
         n++;
      end
      ok = (px(s) == x);
   endtask

   task automatic test_reset();
      repeat (5) tick();
      total++; if (if_full.pixel_x !== 10'd799) $display("FAIL reset_x: got %0d expected 799", if_full.pixel_x); else passed++;
      total++; if (if_full.pixel_y !== 10'd524) $display("FAIL reset_y: got %0d expected 524", if_full.pixel_y); else passed++;
      total++; if (if_full.video_on !== 1'b0) $display("FAIL reset_video_on: got %b expected 0", if_full.video_on); else passed++;
      total++; if (if_full.hsync !== 1'b1 || if_full.vsync !== 1'b1)
         $display("FAIL reset_syncs: got hs=%b vs=%b expected 1 1", if_full.hsync, if_full.vsync); else passed++;
      total++; if (if_full.frame_count !== 8'd0) $display("FAIL reset_frame_count: got %0d expected 0", if_full.frame_count); else passed++;
      total++; if (if_full.frame_start !== 1'b0 || if_full.vblank_start !== 1'b0)
         $display("FAIL reset_pulses: got fs=%b vb=%b expected 0 0", if_full.frame_start, if_full.vblank_start); else passed++;
      rst_full = 1'b1;
      tick();
      total++; if (if_full.pixel_x !== 10'd0 || if_full.pixel_y !== 10'd0)
         $display("FAIL first_pixel: got (%0d,%0d) expected (0,0)", if_full.pixel_x, if_full.pixel_y); else passed++;
      total++; if (if_full.video_on !== 1'b1 || if_full.frame_start !== 1'b1)
         $display("FAIL first_flags: got vo=%b fs=%b expected 1 1", if_full.video_on, if_full.frame_start); else passed++;
      tick();
      total++; if (if_full.pixel_x !== 10'd1 || if_full.frame_start !== 1'b0)
         $display("FAIL second_pixel: got x=%0d fs=%b expected x=1 fs=0", if_full.pixel_x, if_full.frame_start); else passed++;
   endtask

   task automatic test_line_wrap();
      bit ok;
      wait_xy(0, 10'd799, 10'd5, 8000, ok);
      total++; if (!ok) $display("FAIL wrap_reach: got (%0d,%0d) expected (799,5)", px(0), py(0)); else passed++;
      total++; if (if_full.video_on !== 1'b0) $display("FAIL wrap_blank: got %b expected 0", if_full.video_on); else passed++;
      tick();
      total++; if (if_full.pixel_x !== 10'd0 || if_full.pixel_y !== 10'd6 || if_full.video_on !== 1'b1)
         $display("FAIL wrap_next: got (%0d,%0d) vo=%b expected (0,6) vo=1",
                  if_full.pixel_x, if_full.pixel_y, if_full.video_on); else passed++;
      wait_x(0, 10'd639, 1000, ok);
      total++; if (!ok || if_full.video_on !== 1'b1)
         $display("FAIL video_last: got x=%0d vo=%b expected x=639 vo=1", if_full.pixel_x, if_full.video_on); else passed++;
      tick();
      total++; if (if_full.pixel_x !== 10'd640 || if_full.video_on !== 1'b0)
         $display("FAIL video_fall: got x=%0d vo=%b expected x=640 vo=0", if_full.pixel_x, if_full.video_on); else passed++;
   endtask

   task automatic test_hsync(input int s, input int d);
      bit ok;
      int n;
      wait_x(s, 10'd656, 2000, ok);
      total++; if (!ok || hs(s) !== 1'b1)
         $display("FAIL hsync_at656_d%0d: got x=%0d hs=%b expected x=656 hs=1", d, px(s), hs(s)); else passed++;
      for (int i = 0; i < d - 1; i++) begin
         tick();
         total++; if (hs(s) !== 1'b1) $display("FAIL hsync_early_d%0d: got %b expected 1 at x=%0d", d, hs(s), px(s)); else passed++;
      end
      tick();
      total++; if (hs(s) !== 1'b0 || px(s) !== 10'(656 + d))
         $display("FAIL hsync_fall_d%0d: got hs=%b x=%0d expected hs=0 x=%0d", d, hs(s), px(s), 656 + d); else passed++;
      n = 0;
      while (hs(s) == 1'b0 && n < 200) begin
         tick();
         n++;
      end
      total++; if (n != 96) $display("FAIL hsync_width_d%0d: got %0d expected 96", d, n); else passed++;
      total++; if (px(s) !== 10'(752 + d))
         $display("FAIL hsync_rise_d%0d: got x=%0d expected %0d", d, px(s), 752 + d); else passed++;
   endtask

   task automatic test_frame_boundary();
      bit ok;
      int n;
      rst_v = 1'b1;
      tick();
      total++; if (if_v.frame_start !== 1'b1 || if_v.frame_count !== 8'd0)
         $display("FAIL fb_start: got fs=%b fc=%0d expected fs=1 fc=0", if_v.frame_start, if_v.frame_count); else passed++;
      n = 0;
      while (if_v.vblank_start !== 1'b1 && n < 5000) begin
         tick();
         n++;
      end
      total++; if (n != 3200) $display("FAIL fb_spacing: got %0d expected 3200", n); else passed++;
      total++; if (if_v.pixel_x !== 10'd0 || if_v.pixel_y !== 10'd4 || if_v.frame_count !== 8'd1)
         $display("FAIL fb_vblank: got (%0d,%0d) fc=%0d expected (0,4) fc=1",
                  if_v.pixel_x, if_v.pixel_y, if_v.frame_count); else passed++;
      tick();
      total++; if (if_v.vblank_start !== 1'b0 || if_v.frame_count !== 8'd1)
         $display("FAIL fb_vblank_pulse: got vb=%b fc=%0d expected 0 1", if_v.vblank_start, if_v.frame_count); else passed++;
      wait_xy(3, 10'd0, 10'd6, 3000, ok);
      total++; if (!ok || if_v.vsync !== 1'b1)
         $display("FAIL vsync_at_start: got (%0d,%0d) vs=%b expected (0,6) vs=1", px(3), py(3), if_v.vsync); else passed++;
      tick();
      total++; if (if_v.vsync !== 1'b1) $display("FAIL vsync_early: got %b expected 1", if_v.vsync); else passed++;
      tick();
      total++; if (if_v.vsync !== 1'b0) $display("FAIL vsync_fall: got %b expected 0", if_v.vsync); else passed++;
      n = 0;
      while (if_v.vsync == 1'b0 && n < 3000) begin
         tick();
         n++;
      end
      total++; if (n != 1600) $display("FAIL vsync_width: got %0d expected 1600", n); else passed++;
      wait_xy(3, 10'd799, 10'd9, 5000, ok);
      total++; if (!ok || if_v.frame_start !== 1'b0)
         $display("FAIL fb_last: got (%0d,%0d) fs=%b expected (799,9) fs=0", px(3), py(3), if_v.frame_start); else passed++;
      tick();
      total++; if (if_v.pixel_x !== 10'd0 || if_v.pixel_y !== 10'd0 || if_v.frame_start !== 1'b1)
         $display("FAIL fb_wrap: got (%0d,%0d) fs=%b expected (0,0) fs=1",
                  if_v.pixel_x, if_v.pixel_y, if_v.frame_start); else passed++;
   endtask

   task automatic test_reset_mid_sync();
      bit ok;
      int n;
      wait_xy(3, 10'd700, 10'd6, 8000, ok);
      total++; if (!ok || if_v.hsync !== 1'b0 || if_v.vsync !== 1'b0)
         $display("FAIL mid_pre: got hs=%b vs=%b expected 0 0", if_v.hsync, if_v.vsync); else passed++;
      rst_v = 1'b0;
      tick();
      total++; if (if_v.hsync !== 1'b1 || if_v.vsync !== 1'b1)
         $display("FAIL mid_syncs: got hs=%b vs=%b expected 1 1", if_v.hsync, if_v.vsync); else passed++;
      total++; if (if_v.pixel_x !== 10'd799 || if_v.pixel_y !== 10'd9 || if_v.video_on !== 1'b0 || if_v.frame_count !== 8'd0)
         $display("FAIL mid_counters: got (%0d,%0d) vo=%b fc=%0d expected (799,9) vo=0 fc=0",
                  if_v.pixel_x, if_v.pixel_y, if_v.video_on, if_v.frame_count); else passed++;
      tick();
      rst_v = 1'b1;
      tick();
      total++; if (if_v.pixel_x !== 10'd0 || if_v.pixel_y !== 10'd0 || if_v.video_on !== 1'b1 || if_v.frame_start !== 1'b1)
         $display("FAIL mid_restart: got (%0d,%0d) vo=%b fs=%b expected (0,0) vo=1 fs=1",
                  if_v.pixel_x, if_v.pixel_y, if_v.video_on, if_v.frame_start); else passed++;
      wait_xy(3, 10'd657, 10'd0, 1000, ok);
      total++; if (!ok || if_v.hsync !== 1'b1) $display("FAIL mid_hs_657: got %b expected 1", if_v.hsync); else passed++;
      tick();
      total++; if (if_v.hsync !== 1'b0) $display("FAIL mid_hs_658: got %b expected 0", if_v.hsync); else passed++;
      n = 0;
      while (if_v.vblank_start !== 1'b1 && n < 5000) begin
         tick();
         n++;
      end
      total++; if (n != 2542 || if_v.frame_count !== 8'd1)
         $display("FAIL mid_vblank: got n=%0d fc=%0d expected n=2542 fc=1", n, if_v.frame_count); else passed++;
   endtask

   task automatic test_frame_wrap();
      bit timed_out;
      int n;
      timed_out = 1'b0;
      rst_t = 1'b1;
      tick();
      total++; if (if_t.frame_count !== 8'd0) $display("FAIL fc_initial: got %0d expected 0", if_t.frame_count); else passed++;
      for (int k = 1; k <= 256; k++) begin
         n = 0;
         while (if_t.vblank_start !== 1'b1 && n < 100) begin
            tick();
            n++;
         end
         if (n >= 100) begin
            timed_out = 1'b1;
            break;
         end
         if (k == 255) begin
            total++; if (if_t.frame_count !== 8'd255) $display("FAIL fc_255: got %0d expected 255", if_t.frame_count); else passed++;
         end
         if (k == 256) begin
            total++; if (if_t.frame_count !== 8'd0) $display("FAIL fc_wrap: got %0d expected 0", if_t.frame_count); else passed++;
         end
         tick();
      end
      total++; if (timed_out) $display("FAIL fc_timeout: got no vblank_start expected one per 40 cycles"); else passed++;
   endtask

   initial begin
      rst_full = 1'b0;
      rst_d1   = 1'b0;
      rst_d4   = 1'b0;
      rst_v    = 1'b0;
      rst_t    = 1'b0;
      test_reset();
      test_line_wrap();
      test_hsync(0, 2);
      rst_d1 = 1'b1;
      test_hsync(1, 1);
      rst_d4 = 1'b1;
      test_hsync(2, 4);
      test_frame_boundary();
      test_reset_mid_sync();
      test_frame_wrap();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
